// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory
// into a small circular FIFO and presents the head entry to the processor.
module instr_fetch_queue #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instructions,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [1:0]         dbg_state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, cnt_after_pop;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic             mem_req_q, mem_req_d;
  logic [PC_W-1:0]  mem_addr_q, mem_addr_d;
  logic             push;
  logic             pop;

  logic [PC_W-1:0]    pc_mem_q   [DEPTH];
  logic [INSTR_W-1:0] data_mem_q [DEPTH];

  // Handshakes: a head transfer happens on a rising edge where instr_valid
  // and instr_ready are both 1; a memory response completes on a rising edge
  // where mem_req and mem_ack are both 1, and mem_req/mem_addr stay stable
  // until then.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    pop        = (count_q != '0) && instr_ready;
    cnt_after_pop = pop ? count_q - 1'b1 : count_q;

    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      if (state_q == S_IDLE || mem_ack) begin
        state_d    = S_WAIT;
        mem_req_d  = 1'b1;
        mem_addr_d = redirect_pc;
      end else begin
        // Request still in flight: keep it on the bus, discard its data later.
        state_d = S_DROP;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q < FULL) begin
            state_d    = S_WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 1'b1;
            if (cnt_after_pop < FULL_M1) begin
              mem_addr_d = fetch_pc_q + 1'b1;
            end else begin
              state_d   = S_IDLE;
              mem_req_d = 1'b0;
            end
          end
        end
        S_DROP: begin
          if (mem_ack) begin
            state_d    = S_WAIT;
            mem_addr_d = fetch_pc_q;
          end
        end
        default: begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = push ? cnt_after_pop + 1'b1 : cnt_after_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      data_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign instr_valid  = (count_q != '0);
  assign instructions = instr_valid ? data_mem_q[rd_ptr_q] : '0;
  assign instr_pc     = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic, checked
// every cycle against a queue-based behavioural model of the prefetcher.
module tb_instr_fetch_queue;
  localparam int INSTR_W = 16;
  localparam int PC_W    = 8;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [INSTR_W-1:0] instructions;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [1:0]         dbg_state;

  instr_fetch_queue #(.INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .instructions(instructions), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: expected queue contents and the expected memory request
  logic [PC_W+INSTR_W-1:0] exp_q[$];
  logic            m_req   = 1'b0;
  logic [PC_W-1:0] m_addr  = '0;
  logic [PC_W-1:0] m_fetch = '0;
  bit              m_stale = 1'b0;

  // memory responder
  int wait_cnt = 0, ws_cur = 0, ws_min = 0, ws_max = 0, acks_seen = 0;
  bit stray = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  sz;
    bit  pop, acked;
    if (!rst) begin
      exp_q.delete();
      m_req = 1'b0; m_addr = '0; m_fetch = '0; m_stale = 1'b0;
      return;
    end
    sz    = exp_q.size();
    pop   = (sz != 0) && instr_ready;
    acked = m_req && mem_ack;
    if (redirect) begin
      exp_q.delete();
      m_fetch = redirect_pc;
      if (!m_req || acked) begin
        m_req = 1'b1; m_addr = redirect_pc; m_stale = 1'b0;
      end else begin
        m_stale = 1'b1;
      end
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (!m_req) begin
        if (sz < DEPTH) begin
          m_req = 1'b1; m_addr = m_fetch;
        end
      end else if (acked) begin
        if (m_stale) begin
          m_stale = 1'b0; m_addr = m_fetch;
        end else begin
          exp_q.push_back({m_fetch, mem_rdata});
          m_fetch = m_fetch + 1'b1;
          if (exp_q.size() < DEPTH) m_addr = m_fetch;
          else m_req = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [PC_W+INSTR_W-1:0] e;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    chk("instr_pc", 32'(instr_pc), 32'(e[INSTR_W +: PC_W]));
    chk("instructions", 32'(instructions), 32'(e[INSTR_W-1:0]));
  endtask

  // One clock: drive memory response, step model, sample #1 after the edge.
  task automatic cycle();
    logic req_b, rst_b;
    mem_ack   = (mem_req && (wait_cnt >= ws_cur)) || (!mem_req && stray);
    mem_rdata = 16'hA000 + 16'(mem_addr);
    req_b = mem_req;
    rst_b = rst;
    model_step();
    @(posedge clk);
    if (!rst_b) wait_cnt = 0;
    else if (req_b && mem_ack) begin
      acks_seen++;
      wait_cnt = 0;
      ws_cur = int'($urandom_range(ws_max, ws_min));
    end else if (req_b) wait_cnt++;
    #1;
    check_outputs();
    @(negedge clk);
    redirect = 1'b0;
    stray    = 1'b0;
  endtask

  task automatic set_ws(input int lo, input int hi);
    ws_min = lo; ws_max = hi; ws_cur = lo;
  endtask

  initial begin
    int k, n, got;
    logic [PC_W-1:0] wrap_pcs [4];
    wrap_pcs[0] = 8'hFE; wrap_pcs[1] = 8'hFF; wrap_pcs[2] = 8'h00; wrap_pcs[3] = 8'h01;

    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instructions), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_state", 32'(dbg_state), 0);

    // zero wait states, consumer stalled: fill exactly DEPTH entries
    rst = 1'b1; set_ws(0, 0); acks_seen = 0;
    cycle();
    chk("first_req", 32'(mem_req), 1);
    chk("first_addr", 32'(mem_addr), 0);
    repeat (10) cycle();
    chk("fill_acks", 32'(acks_seen), 4);
    chk("fill_req_low", 32'(mem_req), 0);
    chk("fill_valid", 32'(instr_valid), 1);
    chk("fill_head", 32'(instructions), 32'h0000A000);

    // continuous consumption: in-order stream with no gaps or duplicates
    instr_ready = 1'b1; k = 0;
    repeat (30) begin
      if (instr_valid) begin
        chk("stream_order", 32'(instructions), 32'(16'hA000 + 16'(k)));
        k++;
      end
      cycle();
    end
    chk("stream_progress", 32'(k >= 15), 1);

    // redirect during a slow request: pending response is dropped
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 8'h10;
    cycle();
    set_ws(3, 3); wait_cnt = 0;
    cycle();
    redirect = 1'b1; redirect_pc = 8'h40;
    cycle();
    chk("drop_hold_req", 32'(mem_req), 1);
    chk("drop_hold_addr", 32'(mem_addr), 32'h10);
    chk("drop_state", 32'(dbg_state), 2);
    chk("drop_valid", 32'(instr_valid), 0);
    n = 0;
    while (mem_addr !== 8'h40 && n < 20) begin cycle(); n++; end
    chk("redir_addr", 32'(mem_addr), 32'h40);
    n = 0;
    while (!instr_valid && n < 40) begin cycle(); n++; end
    chk("redir_first_pc", 32'(instr_pc), 32'h40);
    chk("redir_first_instr", 32'(instructions), 32'h0000A040);

    // redirect coincident with mem_ack and a head transfer
    set_ws(0, 0);
    redirect = 1'b1; redirect_pc = 8'h20;
    cycle(); cycle(); cycle();
    chk("coinc_pre_valid", 32'(instr_valid), 1);
    chk("coinc_pre_req", 32'(mem_req), 1);
    redirect = 1'b1; redirect_pc = 8'h80; instr_ready = 1'b1;
    cycle();
    chk("coinc_valid", 32'(instr_valid), 0);
    chk("coinc_req", 32'(mem_req), 1);
    chk("coinc_addr", 32'(mem_addr), 32'h80);
    instr_ready = 1'b0;
    cycle();
    chk("coinc_next_pc", 32'(instr_pc), 32'h80);

    // address wrap at 2**PC_W
    set_ws(0, 2); instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 8'hFE;
    cycle();
    got = 0; n = 0;
    while (got < 4 && n < 60) begin
      if (instr_valid) begin
        chk("wrap_pc", 32'(instr_pc), 32'(wrap_pcs[got]));
        got++;
      end
      cycle(); n++;
    end
    chk("wrap_count", 32'(got), 4);

    // reset in the middle of a slow request, then a stale ack
    instr_ready = 1'b0; set_ws(5, 5);
    redirect = 1'b1; redirect_pc = 8'h30;
    cycle();
    wait_cnt = 0;
    cycle(); cycle();
    chk("pre_rst_req", 32'(mem_req), 1);
    rst = 1'b0;
    cycle();
    chk("midrst_req", 32'(mem_req), 0);
    chk("midrst_addr", 32'(mem_addr), 0);
    chk("midrst_valid", 32'(instr_valid), 0);
    chk("midrst_instr", 32'(instructions), 0);
    chk("midrst_pc", 32'(instr_pc), 0);
    rst = 1'b1; stray = 1'b1; set_ws(0, 0);
    cycle();
    chk("postrst_req", 32'(mem_req), 1);
    chk("postrst_addr", 32'(mem_addr), 0);
    chk("postrst_valid", 32'(instr_valid), 0);
    cycle();
    chk("postrst_head_pc", 32'(instr_pc), 0);

    // random traffic against the model
    set_ws(0, 3);
    repeat (600) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect = 1'b1;
        redirect_pc = PC_W'($urandom_range(0, 255));
      end
      stray = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter INSTR_W, 16, instruction width in bits.
REQ-002 Parameter PC_W, 8, word-address width in bits.
REQ-003 Parameter DEPTH, 4, prefetch queue entries (power of two, at least 2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 redirect  input  1  one-cycle pulse; flush the queue and restart fetch.
REQ-007 redirect_pc  input  PC_W  new fetch address; sampled when redirect=1.
REQ-008 instructions  output  INSTR_W  head-of-queue instruction to the Microprocessor.
REQ-009 instr_pc  output  PC_W  word address of the head instruction.
REQ-010 instr_valid  output  1  head entry valid.
REQ-011 instr_ready  input  1  consumer accepts the head; a transfer occurs when instr_valid=1 and instr_ready=1.
REQ-012 mem_req  output  1  instruction memory request.
REQ-013 mem_addr  output  PC_W  request word address.
REQ-014 mem_ack  input  1  memory response; mem_rdata is valid in the same cycle.
REQ-015 mem_rdata  input  INSTR_W  memory read data.

Function
REQ-016 The queue SHALL be a circular FIFO of DEPTH {pc, instruction} entries, with read and write pointers that wrap modulo DEPTH and a count that ranges from 0 to DEPTH.
REQ-017 instr_valid SHALL equal (count != 0), with instructions and instr_pc driven from the head entry combinationally; output latency from memory acknowledge to instr_valid is 1 cycle.
REQ-018 Memory protocol: only one request SHALL be outstanding at a time, and mem_req and mem_addr SHALL be held stable from assertion until the cycle in which mem_ack=1; mem_ack while mem_req=0 SHALL be ignored.
REQ-019 The FSM SHALL have three states: IDLE (mem_req=0), WAIT (mem_req=1, response to be kept) and DROP (mem_req=1, response to be discarded).
REQ-020 IDLE to WAIT: when redirect=0 and count<DEPTH, fetch address fetch_pc is placed on mem_addr and mem_req asserts in the next cycle.
REQ-021 WAIT with mem_ack=1 and redirect=0: push {fetch_pc, mem_rdata}, increment fetch_pc by 1 (wrapping at 2**PC_W), then go to WAIT with the new address if the post-push count is less than DEPTH, otherwise go to IDLE.
REQ-022 A request SHALL issue only when count<DEPTH, so the queue SHALL never overflow; a pop during WAIT only frees space.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-024 Redirect in any state SHALL set count, rd_ptr and wr_ptr to 0 and load fetch_pc with redirect_pc; any transfer in that cycle is a completed handshake but is not replayed.
REQ-025 Redirect in IDLE, or in WAIT/DROP together with mem_ack=1, SHALL discard that cycle's response and go to WAIT with mem_addr=redirect_pc next cycle.
REQ-026 Redirect in WAIT or DROP with mem_ack=0 SHALL move to (or stay in) DROP with mem_req and the old mem_addr held; a later redirect in DROP only reloads fetch_pc.
REQ-027 DROP with mem_ack=1 SHALL discard mem_rdata, push nothing, and go to WAIT with mem_addr=fetch_pc.
REQ-028 instr_valid SHALL be 0 in the cycle after any redirect.

Reset
REQ-029 When rst=0 at a rising edge, the block SHALL set state=IDLE, count=0, both pointers=0, fetch_pc=0, mem_req=0, mem_addr=0, instr_valid=0, instructions=0 and instr_pc=0.
REQ-030 Reset mid-request SHALL abandon the outstanding request without waiting for mem_ack; a stale mem_ack after reset, seen while mem_req=0, SHALL be ignored.
REQ-031 The first request SHALL issue to address 0 in the cycle after rst returns to 1.

Verification
REQ-032 Memory with zero wait states (ack in the first request cycle), data=0xA000+addr, instr_ready=0 -> exactly 4 pushes (pc 0..3), then mem_req=0, instr_valid=1, instructions=0xA000.
REQ-033 Then instr_ready=1 continuously -> instructions 0xA000, 0xA001, ... in order with no gaps or duplicates, and count never exceeds 4.
REQ-034 Memory with 3 wait states and redirect to 0x40 in the second WAIT cycle -> the pending response is dropped, the next mem_addr=0x40, and the first instruction out has instr_pc=0x40.
REQ-035 Redirect coincident with mem_ack and a transfer -> the queue is empty next cycle, no push occurs, and the next mem_addr equals redirect_pc.
REQ-036 Fetch from 0xFE with PC_W=8 -> instr_pc sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-037 rst=0 asserted during WAIT while the memory acks late -> all outputs are 0 after reset, no stale push occurs, and the first request after reset is to address 0.
